// File: rtl/_reg_wr_arbiter.sv
//------------------------------------------------------------------------------
// _reg_wr_arbiter
//   Round-robin write arbiter for one shared enable-register. Up to N
//   requesters post a write (req + data); at most one winner per cycle drives
//   the register's enable/data, and that winner receives a one-cycle ack.
//   The requester acked last cycle is masked for one cycle, so a request
//   still high while its ack is visible is not mistaken for a new one.
//
// Parameters
//   N    number of requesters (>= 2)
//   n    data width in bits (shared register word length)
//   IDW  grant_id width, derived from N
//
// Ports
//   clk       in   1     clock, rising edge
//   rst       in   1     asynchronous reset, active-low
//   stall     in   1     1 = no new grant this cycle
//   req       in   N     req[i] = requester i has a pending write
//   data      in   N*n   requester i data at data[i*n +: n]
//   reg_en    out  1     registered enable to the shared register
//   reg_d     out  n     registered data to the shared register
//   ack       out  N     one-hot, one-cycle pulse for the issued requester
//   grant_id  out  IDW   index of the current winner, valid while reg_en=1
//   busy      out  1     some eligible request was left ungranted last cycle
//------------------------------------------------------------------------------
module _reg_wr_arbiter #(
   parameter int N   = 4,
   parameter int n   = 8,
   localparam int IDW = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic [N-1:0]     req,
   input  logic [N*n-1:0]   data,
   output logic             reg_en,
   output logic [n-1:0]     reg_d,
   output logic [N-1:0]     ack,
   output logic [IDW-1:0]   grant_id,
   output logic             busy
);

   logic             r_reg_en;
   logic [n-1:0]     r_reg_d;
   logic [N-1:0]     r_ack;
   logic [IDW-1:0]   r_grant_id;
   logic             r_busy;
   logic [IDW-1:0]   r_ptr;
   logic [N-1:0]     r_mask;

   logic [N-1:0]     w_eligible;
   logic             w_found;
   logic             w_grant;
   logic [IDW-1:0]   w_win;
   logic [N-1:0]     w_win_oh;
   logic [n-1:0]     w_win_data;
   logic [IDW-1:0]   w_ptr_next;
   logic             w_busy_next;

   // Round-robin scan starting at r_ptr; first eligible index wins.
   always_comb begin
      // NOTE: every comb output gets a default before any branch, so no
      // path leaves a value unassigned and no latch is inferred.
      w_eligible = req & ~r_mask;
      w_found    = 1'b0;
      w_win      = '0;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = int'(r_ptr) + k;
         if (idx >= N) idx = idx - N;
         if (!w_found && w_eligible[idx]) begin
            w_found = 1'b1;
            w_win   = IDW'(idx);
         end
      end

      w_grant  = w_found & ~stall;
      w_win_oh = '0;
      if (w_grant) w_win_oh[w_win] = 1'b1;

      w_win_data  = data[int'(w_win)*n +: n];
      // N need not be a power of two, so wrap explicitly.
      w_ptr_next  = (w_win == IDW'(N-1)) ? '0 : w_win + 1'b1;
      w_busy_next = |(w_eligible & ~w_win_oh);
   end

   // NOTE: all state updates use non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_reg_en   <= 1'b0;
         r_reg_d    <= '0;
         r_ack      <= '0;
         r_grant_id <= '0;
         r_busy     <= 1'b0;
         r_ptr      <= '0;
         r_mask     <= '0;
      end else begin
         r_busy <= w_busy_next;
         if (w_grant) begin
            r_reg_en   <= 1'b1;
            r_reg_d    <= w_win_data;
            r_grant_id <= w_win;
            r_ack      <= w_win_oh;
            r_ptr      <= w_ptr_next;
            r_mask     <= w_win_oh;
         end else begin
            // reg_d, grant_id and ptr hold; a stall also clears the mask.
            r_reg_en <= 1'b0;
            r_ack    <= '0;
            r_mask   <= '0;
         end
      end
   end

   assign reg_en   = r_reg_en;
   assign reg_d    = r_reg_d;
   assign ack      = r_ack;
   assign grant_id = r_grant_id;
   assign busy     = r_busy;

endmodule
